// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and flush controller for the in-order pipeline.
// A DEPTH-slot shift scoreboard tracks every in-flight writer downstream of decode.
module hazard_scoreboard #(
  parameter int REG_BITS  = 3,
  parameter int DEPTH     = 3,
  parameter int FWD_EN    = 1,
  parameter int WB_BYPASS = 1,
  parameter int BR_SLOT   = 0,
  parameter int CNT_W     = 16,
  localparam int FSW      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic                id_rs_rd,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_rt_rd,
  input  logic                id_wr_en,
  input  logic [REG_BITS-1:0] id_wreg,
  input  logic                id_is_load,
  input  logic                br_taken,
  output logic                stall_id,
  output logic                flush,
  output logic [FSW-1:0]      fwd_sel_a,
  output logic [FSW-1:0]      fwd_sel_b,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  logic [DEPTH-1:0]    r_valid;
  logic [DEPTH-1:0]    r_isLoad;
  logic [REG_BITS-1:0] r_wreg [DEPTH];
  logic [CNT_W-1:0]    r_stallCnt;
  logic [CNT_W-1:0]    r_flushCnt;

  logic [DEPTH-1:0]    w_matchA;
  logic [DEPTH-1:0]    w_matchB;
  logic [DEPTH-1:0]    w_eligA;
  logic [DEPTH-1:0]    w_eligB;
  logic                w_hazard;
  logic [FSW-1:0]      w_selA;
  logic [FSW-1:0]      w_selB;

  logic [DEPTH-1:0]    w_nValid;
  logic [DEPTH-1:0]    w_nIsLoad;
  logic [REG_BITS-1:0] w_nWreg [DEPTH];

  // With a write-before-read regfile the oldest slot is already visible to ID.
  always_comb begin
    w_matchA = '0;
    w_matchB = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!(WB_BYPASS != 0 && k == DEPTH - 1)) begin
        w_matchA[k] = r_valid[k] && (r_wreg[k] == id_rs) && id_rs_rd && id_valid;
        w_matchB[k] = r_valid[k] && (r_wreg[k] == id_rt) && id_rt_rd && id_valid;
      end
    end
  end

  always_comb begin
    w_hazard = 1'b0;
    if (FWD_EN != 0) begin
      w_hazard = (w_matchA[0] || w_matchB[0]) && r_isLoad[0];
    end else begin
      w_hazard = |(w_matchA | w_matchB);
    end
  end

  // A load in EX has no result yet, so it is never a forwarding source.
  always_comb begin
    w_eligA = w_matchA;
    w_eligB = w_matchB;
    w_eligA[0] = w_matchA[0] && !r_isLoad[0];
    w_eligB[0] = w_matchB[0] && !r_isLoad[0];
    w_selA = '0;
    w_selB = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_eligA[k]) w_selA = FSW'(k + 1);
      if (w_eligB[k]) w_selB = FSW'(k + 1);
    end
  end

  assign stall_id  = w_hazard && !br_taken;
  assign flush     = br_taken;
  assign fwd_sel_a = (FWD_EN != 0) ? w_selA : '0;
  assign fwd_sel_b = (FWD_EN != 0) ? w_selB : '0;
  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;

  always_comb begin
    w_nValid     = '0;
    w_nIsLoad    = '0;
    w_nWreg[0]   = id_wreg;
    w_nValid[0]  = id_valid && id_wr_en;
    w_nIsLoad[0] = id_is_load;
    for (int k = 1; k < DEPTH; k++) begin
      w_nValid[k]  = r_valid[k-1];
      w_nIsLoad[k] = r_isLoad[k-1];
      w_nWreg[k]   = r_wreg[k-1];
    end
    // A taken branch squashes its younger slots and the ID entry; older ones still drain.
    if (br_taken) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (k <= BR_SLOT) w_nValid[k] = 1'b0;
      end
    end else if (w_hazard) begin
      w_nValid[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= '0;
      r_isLoad <= '0;
      for (int k = 0; k < DEPTH; k++) r_wreg[k] <= '0;
    end else if (!freeze) begin
      r_valid  <= w_nValid;
      r_isLoad <= w_nIsLoad;
      for (int k = 0; k < DEPTH; k++) r_wreg[k] <= w_nWreg[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else if (!freeze) begin
      if (br_taken) begin
        if (r_flushCnt != '1) r_flushCnt <= r_flushCnt + 1'b1;
      end else if (w_hazard) begin
        if (r_stallCnt != '1) r_stallCnt <= r_stallCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard: a default instance plus a
// no-forwarding instance with narrow counters, both fed the same ID stream.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       freeze = 1'b0;
  logic       idValid = 1'b0;
  logic [2:0] idRs = '0;
  logic       idRsRd = 1'b0;
  logic [2:0] idRt = '0;
  logic       idRtRd = 1'b0;
  logic       idWrEn = 1'b0;
  logic [2:0] idWreg = '0;
  logic       idIsLoad = 1'b0;
  logic       brTaken = 1'b0;

  logic        stallId, flushO;
  logic [1:0]  fwdA, fwdB;
  logic [15:0] stallCnt, flushCnt;

  logic        nfStallId, nfFlush;
  logic [1:0]  nfFwdA, nfFwdB;
  logic [1:0]  nfStallCnt, nfFlushCnt;

  int checkCnt = 0;
  int errCnt = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .id_valid(idValid), .id_rs(idRs), .id_rs_rd(idRsRd),
    .id_rt(idRt), .id_rt_rd(idRtRd), .id_wr_en(idWrEn),
    .id_wreg(idWreg), .id_is_load(idIsLoad), .br_taken(brTaken),
    .stall_id(stallId), .flush(flushO), .fwd_sel_a(fwdA), .fwd_sel_b(fwdB),
    .stall_cnt(stallCnt), .flush_cnt(flushCnt)
  );

  hazard_scoreboard #(.FWD_EN(0), .CNT_W(2)) u_dutNf (
    .clk(clk), .rst(rst), .freeze(freeze),
    .id_valid(idValid), .id_rs(idRs), .id_rs_rd(idRsRd),
    .id_rt(idRt), .id_rt_rd(idRtRd), .id_wr_en(idWrEn),
    .id_wreg(idWreg), .id_is_load(idIsLoad), .br_taken(brTaken),
    .stall_id(nfStallId), .flush(nfFlush), .fwd_sel_a(nfFwdA), .fwd_sel_b(nfFwdB),
    .stall_cnt(nfStallCnt), .flush_cnt(nfFlushCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCnt++;
    if (observed !== expected) begin
      errCnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] rs, input logic rsRd,
                               input logic [2:0] rt, input logic rtRd, input logic wrEn,
                               input logic [2:0] wreg, input logic isLoad);
    idValid  = v;
    idRs     = rs;
    idRsRd   = rsRd;
    idRt     = rt;
    idRtRd   = rtRd;
    idWrEn   = wrEn;
    idWreg   = wreg;
    idIsLoad = isLoad;
  endtask

  // Inputs change 1 ns after the rising edge; checks land mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    brTaken = 1'b0;
    freeze  = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    doReset();
    #2;
    checkOutput("rstStall", stallId, 0);
    checkOutput("rstFlush", flushO, 0);
    checkOutput("rstFwdA", fwdA, 0);
    checkOutput("rstFwdB", fwdB, 0);
    checkOutput("rstStallCnt", stallCnt, 0);
    checkOutput("rstFlushCnt", flushCnt, 0);

    // ALU result forwarded from EX, then MEM, then nothing once in WB
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 0);
    tick();
    applyStimulus(1, 3, 1, 0, 0, 0, 0, 0);
    #2;
    checkOutput("fwdExA", fwdA, 1);
    checkOutput("fwdExStall", stallId, 0);
    checkOutput("fwdExB", fwdB, 0);
    tick();
    #2;
    checkOutput("fwdMemA", fwdA, 2);
    tick();
    #2;
    checkOutput("wbBypassA", fwdA, 0);

    // Load-use stall for one cycle, then forward from MEM
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 2, 1);
    tick();
    applyStimulus(1, 0, 0, 2, 1, 0, 0, 0);
    #2;
    checkOutput("luStall", stallId, 1);
    checkOutput("luFwdB", fwdB, 0);
    tick();
    #2;
    checkOutput("luStallCnt", stallCnt, 1);
    checkOutput("luStallDone", stallId, 0);
    checkOutput("luFwdMemB", fwdB, 2);

    // Youngest producer wins
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 0);
    tick();
    tick();
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0);
    #2;
    checkOutput("youngestA", fwdA, 1);

    // Load in EX shadows an older ALU write: stall, select the older match
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 1);
    tick();
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0);
    #2;
    checkOutput("loadShadowStall", stallId, 1);
    checkOutput("loadShadowA", fwdA, 2);

    // No-forwarding instance stalls until the writer reaches WB
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0);
    tick();
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    #2;
    checkOutput("nfStall0", nfStallId, 1);
    checkOutput("nfFwdA0", nfFwdA, 0);
    checkOutput("nfDefNoStall", stallId, 0);
    tick();
    #2;
    checkOutput("nfStall1", nfStallId, 1);
    checkOutput("nfFwdA1", nfFwdA, 0);
    tick();
    #2;
    checkOutput("nfStall2", nfStallId, 0);
    checkOutput("nfStallCnt", nfStallCnt, 2);

    // Taken branch overrides a pending load-use stall
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 2, 1);
    tick();
    applyStimulus(1, 0, 0, 2, 1, 1, 6, 0);
    brTaken = 1'b1;
    #2;
    checkOutput("brFlush", flushO, 1);
    checkOutput("brNoStall", stallId, 0);
    tick();
    brTaken = 1'b0;
    applyStimulus(1, 6, 1, 2, 1, 0, 0, 0);
    #2;
    checkOutput("brSquashA", fwdA, 0);
    checkOutput("brShiftB", fwdB, 2);
    checkOutput("brAfterStall", stallId, 0);
    checkOutput("brAfterFlush", flushO, 0);
    checkOutput("brFlushCnt", flushCnt, 1);
    checkOutput("brStallCnt", stallCnt, 0);

    // Flush counter saturation on the 2-bit instance
    doReset();
    brTaken = 1'b1;
    repeat (5) tick();
    brTaken = 1'b0;
    #2;
    checkOutput("flushCnt5", flushCnt, 5);
    checkOutput("nfFlushSat", nfFlushCnt, 3);

    // Freeze during a load-use stall, then asynchronous reset mid-freeze
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 2, 1);
    tick();
    applyStimulus(1, 0, 0, 2, 1, 0, 0, 0);
    tick();
    tick();
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 1);
    tick();
    applyStimulus(1, 4, 1, 0, 0, 0, 0, 0);
    freeze = 1'b1;
    #2;
    checkOutput("frzStall", stallId, 1);
    repeat (4) tick();
    #2;
    checkOutput("frzStallHeld", stallId, 1);
    checkOutput("frzStallCnt", stallCnt, 1);
    rst = 1'b1;
    #1;
    checkOutput("asyncRstStall", stallId, 0);
    checkOutput("asyncRstFwdA", fwdA, 0);
    checkOutput("asyncRstStallCnt", stallCnt, 0);
    checkOutput("asyncRstNfStall", nfStallId, 0);
    rst = 1'b0;
    freeze = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
